fifo_drain_reader: RTL and testbench

- Consumer-side controller for the team's 8-bit synchronous FIFO.
- Pops entries through the FIFO's rd_en/buf_empty/buf_out interface and absorbs the FIFO's 1-cycle registered read latency in an internal skid buffer.
- Presents the words downstream on a valid/ready stream, with burst framing (out_last) and a running word count.
- Sits directly on the FIFO's read port and feeds any downstream consumer (serializer, packetizer).

---
 rtl/fifo_drain_reader.sv | 86 ++++++++
 tb/tb_fifo_drain_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_reader.sv
// Consumer-side reader for the 8-bit synchronous FIFO: pops words, absorbs the
// one-cycle read latency in a small skid buffer and streams them out with burst framing.
module fifo_drain_reader #(
  parameter int unsigned DW         = 8,
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd_en,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [15:0]   word_count,
  output logic          busy
);

  localparam int unsigned PW  = $clog2(SKID_DEPTH);
  localparam int unsigned OW  = PW + 1;
  localparam int unsigned BW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WCW = 16;

  logic [DW-1:0]  mem [SKID_DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [OW-1:0]  occ;
  logic           inflight;
  logic [BW-1:0]  beat_cnt;
  logic [WCW-1:0] wcnt;

  logic valid_c;
  logic last_c;
  logic fire_c;

  // Capacity counts only registered state, so downstream ready never reaches the FIFO read.
  assign fifo_rd_en = !rst && enable && !fifo_empty &&
                      ((occ + OW'(inflight)) < OW'(SKID_DEPTH));

  assign valid_c = !rst && (occ != '0);
  assign last_c  = valid_c && (beat_cnt == BW'(BURST_LEN - 1));
  assign fire_c  = valid_c && out_ready;

  assign out_valid  = valid_c;
  assign out_last   = last_c;
  assign out_data   = valid_c ? mem[head] : '0;
  assign word_count = rst ? '0 : wcnt;
  assign busy       = !rst && (inflight || (occ != '0));

  // Skid storage: the word requested last cycle lands at tail.
  always_ff @(posedge clk) begin
    if (!rst && inflight) begin
      mem[tail] <= fifo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      beat_cnt <= '0;
      wcnt     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        tail <= tail + PW'(1);
      end
      if (fire_c) begin
        head     <= head + PW'(1);
        wcnt     <= wcnt + WCW'(1);
        beat_cnt <= last_c ? '0 : beat_cnt + BW'(1);
      end
      if (inflight && !fire_c) begin
        occ <= occ + OW'(1);
      end else if (!inflight && fire_c) begin
        occ <= occ - OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Directed bench for fifo_drain_reader: a queue-backed FIFO model with one-cycle
// registered read data, a cycle-by-cycle backpressure vector table and hand sequences.
module tb_fifo_drain_reader;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] word_count;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  fifo_drain_reader #(.DW(8), .SKID_DEPTH(4), .BURST_LEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .word_count (word_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: pushes happen at negedge from the test, pops at posedge with registered data.
  logic [7:0] q [$];
  int n_push = 0;
  int n_pop  = 0;
  assign fifo_empty = (n_push == n_pop);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= q.pop_front();
      n_pop     <= n_pop + 1;
    end
  end

  // A capture into a full skid buffer would mean an overrun.
  always @(posedge clk) begin
    if (!rst && dut.inflight && (dut.occ == 3'd4)) begin
      n_vec++;
      n_err++;
      $display("FAIL skid_overflow: capture with occ=%0d, required occ<4 at %0t", dut.occ, $time);
    end
  end

  typedef struct {
    logic       en;
    logic       rdy;
    logic       exp_rd;
    logic       exp_vld;
    logic [7:0] exp_data;
    logic       exp_last;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input logic en, input logic rdy, input logic rd, input logic vld,
                              input logic [7:0] d, input logic last, input logic bsy);
    vec_t v;
    v.en = en; v.rdy = rdy; v.exp_rd = rd; v.exp_vld = vld;
    v.exp_data = d; v.exp_last = last; v.exp_busy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    n_push++;
  endtask

  task automatic flush();
    q.delete();
    n_push = n_pop;
  endtask

  // Leaves the caller at the negedge of the first cycle after reset.
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    flush();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_wc;
    int idx;
    int pulses;
    int c;

    // Backpressure table: 10 words queued, ready low 8 cycles, then toggling.
    tbl[0] = mk(1, 0, 1, 0, 8'h00, 0, 0);
    tbl[1] = mk(1, 0, 1, 0, 8'h00, 0, 1);
    tbl[2] = mk(1, 0, 1, 1, 8'hA0, 0, 1);
    tbl[3] = mk(1, 0, 1, 1, 8'hA0, 0, 1);
    for (int i = 4; i < 8; i++) tbl[i] = mk(1, 0, 0, 1, 8'hA0, 0, 1);
    tbl[8] = mk(1, 1, 0, 1, 8'hA0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      tbl[9 + 2*i]  = mk(1, 0, 1, 1, 8'(8'hA1 + i), 0, 1);
      tbl[10 + 2*i] = mk(1, 1, 0, 1, 8'(8'hA1 + i), 0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      tbl[21 + 2*i] = mk(1, 0, 0, 1, 8'(8'hA7 + i), 0, 1);
      tbl[22 + 2*i] = mk(1, 1, 0, 1, 8'(8'hA7 + i), 0, 1);
    end
    tbl[27] = mk(1, 0, 0, 0, 8'h00, 0, 0);

    // Reset with FIFO preloaded and reads requested
    rst = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 32; i++) push(8'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rst%0d_rd_en", i), 32'(fifo_rd_en), 0);
      chk($sformatf("rst%0d_valid", i), 32'(out_valid), 0);
      chk($sformatf("rst%0d_data", i), 32'(out_data), 0);
      chk($sformatf("rst%0d_wc", i), 32'(word_count), 0);
      chk($sformatf("rst%0d_busy", i), 32'(busy), 0);
    end

    // Streaming 0x01..0x20 at full rate
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stream_c0_rd_en", 32'(fifo_rd_en), 1);
    chk("stream_c0_valid", 32'(out_valid), 0);
    @(negedge clk); #1;
    chk("stream_c1_valid", 32'(out_valid), 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); #1;
      chk($sformatf("stream%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("stream%0d_data", i), 32'(out_data), 32'(i + 1));
      chk($sformatf("stream%0d_last", i), 32'(out_last), ((i + 1) % 16 == 0) ? 1 : 0);
    end
    @(negedge clk); #1;
    chk("stream_end_valid", 32'(out_valid), 0);
    chk("stream_end_wc", 32'(word_count), 32);
    chk("stream_end_busy", 32'(busy), 0);

    // Mid-operation reset with occ=3 and a word in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'hB0 + i));
    #1;
    chk("midrst_c0_rd_en", 32'(fifo_rd_en), 1);
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_c4_rd_en", 32'(fifo_rd_en), 0);
    chk("midrst_c4_valid", 32'(out_valid), 1);
    chk("midrst_c4_data", 32'(out_data), 32'hB0);
    chk("midrst_c4_busy", 32'(busy), 1);
    rst = 1'b1;
    flush();
    #1;
    chk("midrst_during_valid", 32'(out_valid), 0);
    chk("midrst_during_rd_en", 32'(fifo_rd_en), 0);
    chk("midrst_during_wc", 32'(word_count), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_after_busy", 32'(busy), 0);
    chk("midrst_after_valid", 32'(out_valid), 0);
    chk("midrst_after_wc", 32'(word_count), 0);
    push(8'hC0);
    #1;
    chk("midrst_new_rd_en", 32'(fifo_rd_en), 1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("midrst_new_valid", 32'(out_valid), 1);
    chk("midrst_new_data", 32'(out_data), 32'hC0);

    // Enable dropped right after a read is issued
    reset_dut();
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'hD0 + i));
    #1;
    chk("en_c0_rd_en", 32'(fifo_rd_en), 1);
    @(negedge clk);
    enable = 1'b0;
    #1;
    chk("en_c1_rd_en", 32'(fifo_rd_en), 0);
    chk("en_c1_busy", 32'(busy), 1);
    @(negedge clk); #1;
    chk("en_c2_valid", 32'(out_valid), 1);
    chk("en_c2_data", 32'(out_data), 32'hD0);
    @(negedge clk); #1;
    chk("en_c3_valid", 32'(out_valid), 0);
    chk("en_c3_busy", 32'(busy), 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (fifo_rd_en) pulses++;
    end
    chk("en_idle_reads", 32'(pulses), 0);
    chk("en_wc", 32'(word_count), 1);

    // Backpressure vector table
    reset_dut();
    for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
    exp_wc = '0;
    for (int k = 0; k < 28; k++) begin
      enable = tbl[k].en;
      out_ready = tbl[k].rdy;
      #1;
      chk($sformatf("bp%0d_rd_en", k), 32'(fifo_rd_en), 32'(tbl[k].exp_rd));
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'(tbl[k].exp_vld));
      chk($sformatf("bp%0d_data", k), 32'(out_data), 32'(tbl[k].exp_data));
      chk($sformatf("bp%0d_last", k), 32'(out_last), 32'(tbl[k].exp_last));
      chk($sformatf("bp%0d_busy", k), 32'(busy), 32'(tbl[k].exp_busy));
      chk($sformatf("bp%0d_wc", k), 32'(word_count), 32'(exp_wc));
      if (tbl[k].rdy && tbl[k].exp_vld) exp_wc++;
      @(negedge clk);
    end

    // FIFO running empty between single words; burst count carries across the gap
    reset_dut();
    enable = 1'b1;
    out_ready = 1'b1;
    push(8'h5A);
    #1;
    chk("empty_c0_rd_en", 32'(fifo_rd_en), 1);
    @(negedge clk); #1;
    chk("empty_c1_rd_en", 32'(fifo_rd_en), 0);
    chk("empty_c1_valid", 32'(out_valid), 0);
    @(negedge clk); #1;
    chk("empty_c2_valid", 32'(out_valid), 1);
    chk("empty_c2_data", 32'(out_data), 32'h5A);
    chk("empty_c2_last", 32'(out_last), 0);
    @(negedge clk); #1;
    chk("empty_c3_valid", 32'(out_valid), 0);
    chk("empty_c3_busy", 32'(busy), 0);
    @(negedge clk);
    push(8'h5B);
    #1;
    chk("empty_c4_rd_en", 32'(fifo_rd_en), 1);
    @(negedge clk); #1;
    chk("empty_c5_rd_en", 32'(fifo_rd_en), 0);
    chk("empty_c5_valid", 32'(out_valid), 0);
    @(negedge clk); #1;
    chk("empty_c6_data", 32'(out_data), 32'h5B);
    chk("empty_c6_last", 32'(out_last), 0);
    @(negedge clk);
    for (int i = 0; i < 14; i++) push(8'(8'h60 + i));
    idx = 2;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (fifo_rd_en) pulses++;
      if (out_valid) begin
        chk($sformatf("burst_w%0d_data", idx), 32'(out_data), 32'(8'h60 + idx - 2));
        chk($sformatf("burst_w%0d_last", idx), 32'(out_last), (idx == 15) ? 1 : 0);
        idx++;
      end
      @(negedge clk);
    end
    chk("burst_words", 32'(idx), 16);
    chk("burst_reads", 32'(pulses), 14);

    // word_count wrap after 65535 transfers
    reset_dut();
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) push(8'(i));
    c = 0;
    #1;
    while (word_count !== 16'hFFFF && c < 70000) begin
      @(negedge clk); #1;
      c++;
    end
    chk("wrap_wc_ffff", 32'(word_count), 32'hFFFF);
    chk("wrap_drained_valid", 32'(out_valid), 0);
    @(negedge clk);
    push(8'hEE);
    #1;
    chk("wrap_rd_en", 32'(fifo_rd_en), 1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("wrap_valid", 32'(out_valid), 1);
    chk("wrap_data", 32'(out_data), 32'hEE);
    chk("wrap_last", 32'(out_last), 1);
    @(negedge clk); #1;
    chk("wrap_wc_zero", 32'(word_count), 0);
    chk("wrap_end_valid", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
